multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
Main control FSM for the multicycle RV32 datapath, directly upstream of the ALU control block. It decodes the instruction-register opcode, sequences fetch/decode/execute/memory/writeback steps, and drives every datapath enable. This includes the ALUOp1/ALUOp0 pair consumed by ALU control: 00 = add for address and PC arithmetic, 01 = subtract for the branch compare, 10 = use funct fields for R-type. Supported subset: lw, sw, R-type, beq; any other opcode is flagged illegal.

Parameters:
OPC_LW, 7'b0000011, load opcode
OPC_SW, 7'b0100011, store opcode
OPC_R, 7'b0110011, R-type opcode
OPC_BEQ, 7'b1100011, branch-equal opcode

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  7  IR[6:0]; valid from DECODE onward
mem_ready  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC write
PCWriteCond  output  1  PC write if ALU Zero
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  writeback select: 0 = ALUOut, 1 = MDR
PCSource  output  1  PC source: 0 = ALU result, 1 = ALUOut
ALUOp1  output  1  to ALU control
ALUOp0  output  1  to ALU control
ALUSrcA  output  2  ALU A select: 00 = PC, 01 = reg A, 10 = OldPC
ALUSrcB  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = immediate
RegWrite  output  1  register file write
illegal  output  1  one-cycle pulse on unsupported opcode
state  output  4  current state code, for debug

Behaviour:
- Moore FSM. Outputs decode from the state register, except the mem_ready gating listed below. One state register, 4 bits.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9. Codes 10-15 go to IDLE on the next edge.
- Reset: asserting reset forces IDLE immediately, including mid-instruction. In IDLE every output is 0, including state=0. IDLE always goes to FETCH on the next edge.
- Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, ALUSrcA=00, ALUSrcB=01, ALUOp=00, IorD=0, PCSource=0.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch target into ALUOut).
  - Next state by opcode: LW or SW -> MEMADR; R -> EXEC; BEQ -> BRANCH; other -> FETCH with illegal=1 this cycle only.
- MEMADR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds while mem_ready=0; goes to MEMWB when mem_ready=1.
- MEMWB: RegWrite=1, MemtoReg=1. Next: FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds while mem_ready=0; goes to FETCH when mem_ready=1. MemWrite stays high across all stall cycles.
- EXEC: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0. Next: FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1. Next: FETCH.
- Latency with mem_ready held at 1, FETCH to next FETCH: beq 3, R-type 4, sw 4, lw 5, illegal 2 cycles.
- Each memory stall cycle adds one cycle.
- opcode is ignored outside DECODE and MEMADR.
- Invariants:
  - MemRead and MemWrite are never both 1.
  - RegWrite is never 1 in the same cycle as MemRead or MemWrite.

Test Plan:
- Reset/IDLE: assert reset mid-EXEC -> state=0 and all outputs 0 without waiting for a clock edge; after release, 1 cycle in IDLE, then state=1 with MemRead=1 and ALUSrcB=01.
- R-type, mem_ready=1: opcode=0110011 -> states 1,2,7,8,1; in state 7 ALUOp1=1, ALUOp0=0, ALUSrcA=01; RegWrite=1 only in state 8.
- lw with a 2-cycle read stall: mem_ready=0 for the first 2 cycles of MEMRD -> states 1,2,3,4,4,4,5,1; MemRead=IorD=1 in every state-4 cycle; RegWrite=MemtoReg=1 in state 5.
- sw plus fetch stall: mem_ready=0 for 3 cycles in FETCH -> IRWrite=PCWrite=0 for those 3 cycles and 1 on the accept cycle; then states 2,3,6,1 with MemWrite=1 only in state 6.
- beq: opcode=1100011 -> states 1,2,9,1; in state 9 ALUOp1=0, ALUOp0=1, PCWriteCond=1, PCSource=1.
- Illegal: opcode=0010111 -> illegal=1 for exactly the DECODE cycle, then FETCH; RegWrite, MemWrite and PCWriteCond never asserted.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RV32 datapath (lw, sw, R-type, beq).
// Moore outputs decoded from the state register; only FETCH looks at mem_ready.
module multicycle_main_control #(
  parameter logic [6:0] OPC_LW  = 7'b0000011,
  parameter logic [6:0] OPC_SW  = 7'b0100011,
  parameter logic [6:0] OPC_R   = 7'b0110011,
  parameter logic [6:0] OPC_BEQ = 7'b1100011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       PCSource,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] FETCH  = 4'd1;
  localparam logic [3:0] DECODE = 4'd2;
  localparam logic [3:0] MEMADR = 4'd3;
  localparam logic [3:0] MEMRD  = 4'd4;
  localparam logic [3:0] MEMWB  = 4'd5;
  localparam logic [3:0] MEMWR  = 4'd6;
  localparam logic [3:0] EXEC   = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;

  logic [3:0] state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   state_nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (opcode == OPC_LW || opcode == OPC_SW) state_nxt = MEMADR;
        else if (opcode == OPC_R)                 state_nxt = EXEC;
        else if (opcode == OPC_BEQ)               state_nxt = BRANCH;
        else                                      state_nxt = FETCH;
      end
      // IR cannot change mid-instruction; a non-memory opcode here just restarts fetch.
      MEMADR: begin
        if (opcode == OPC_SW)      state_nxt = MEMWR;
        else if (opcode == OPC_LW) state_nxt = MEMRD;
        else                       state_nxt = FETCH;
      end
      MEMRD:   state_nxt = mem_ready ? MEMWB : MEMRD;
      MEMWB:   state_nxt = FETCH;
      MEMWR:   state_nxt = mem_ready ? FETCH : MEMWR;
      EXEC:    state_nxt = ALUWB;
      ALUWB:   state_nxt = FETCH;
      BRANCH:  state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = 1'b0;
    ALUOp1      = 1'b0;
    ALUOp0      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    illegal     = 1'b0;
    case (state)
      // PC+4 is computed every FETCH cycle but only committed on the accept cycle.
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
        illegal = !(opcode == OPC_LW || opcode == OPC_SW ||
                    opcode == OPC_R  || opcode == OPC_BEQ);
      end
      MEMADR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 2'b01;
        ALUOp1  = 1'b1;
      end
      ALUWB:   RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA     = 2'b01;
        ALUOp0      = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: per-cycle expectations queued
// when inputs are driven, popped and compared mid-cycle.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, PCSource, ALUOp1, ALUOp0, RegWrite, illegal;
  logic [1:0] ALUSrcA, ALUSrcB;
  logic [3:0] state;

  multicycle_main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUOp1(ALUOp1),
    .ALUOp0(ALUOp0), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] BQ = 7'b1100011, BAD = 7'b0010111, JUNK = 7'b1111111;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,PCSource,
  //  ALUOp1,ALUOp0,ALUSrcA[1:0],ALUSrcB[1:0],RegWrite,illegal}
  localparam logic [15:0] O_IDLE   = 16'b0_0_0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [15:0] O_FACC   = 16'b1_0_0_1_0_1_0_0_0_0_00_01_0_0;
  localparam logic [15:0] O_FSTL   = 16'b0_0_0_1_0_0_0_0_0_0_00_01_0_0;
  localparam logic [15:0] O_DEC    = 16'b0_0_0_0_0_0_0_0_0_0_10_10_0_0;
  localparam logic [15:0] O_DECILL = 16'b0_0_0_0_0_0_0_0_0_0_10_10_0_1;
  localparam logic [15:0] O_MADR   = 16'b0_0_0_0_0_0_0_0_0_0_01_10_0_0;
  localparam logic [15:0] O_MRD    = 16'b0_0_1_1_0_0_0_0_0_0_00_00_0_0;
  localparam logic [15:0] O_MWB    = 16'b0_0_0_0_0_0_1_0_0_0_00_00_1_0;
  localparam logic [15:0] O_MWR    = 16'b0_0_1_0_1_0_0_0_0_0_00_00_0_0;
  localparam logic [15:0] O_EXEC   = 16'b0_0_0_0_0_0_0_0_1_0_01_00_0_0;
  localparam logic [15:0] O_AWB    = 16'b0_0_0_0_0_0_0_0_0_0_00_00_1_0;
  localparam logic [15:0] O_BR     = 16'b0_1_0_0_0_0_0_1_0_1_01_00_0_0;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [15:0] o;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [15:0] obs_outputs();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            PCSource, ALUOp1, ALUOp0, ALUSrcA, ALUSrcB, RegWrite, illegal};
  endfunction

  task automatic check();
    exp_t e;
    logic [15:0] o;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      o = obs_outputs();
      vectors++;
      assert (state === e.st) else begin
        miscompares++;
        $error("FAIL %s state observed=%0d expected=%0d", e.tag, state, e.st);
      end
      vectors++;
      assert (o === e.o) else begin
        miscompares++;
        $error("FAIL %s outputs observed=%b expected=%b", e.tag, o, e.o);
      end
      vectors++;
      assert (!(MemRead && MemWrite) && !(RegWrite && (MemRead || MemWrite))) else begin
        miscompares++;
        $error("FAIL %s invariant observed=%b%b%b expected=no_overlap",
               e.tag, MemRead, MemWrite, RegWrite);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic [3:0] st, input logic [15:0] o);
    exp_t e;
    e.tag = tag; e.st = st; e.o = o;
    sb.push_back(e);
  endtask

  task automatic step(input string tag, input logic mr, input logic [6:0] opc,
                      input logic [3:0] st, input logic [15:0] o);
    mem_ready = mr;
    opcode    = opc;
    expect_now(tag, st, o);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 7'd0;
    repeat (2) @(posedge clk);
    expect_now("reset_held", 4'd0, O_IDLE);
    @(negedge clk);
    check();
    @(posedge clk);
    #1 reset = 1'b0;

    step("idle",        1'b1, JUNK, 4'd0, O_IDLE);
    // R-type
    step("r_fetch",     1'b1, JUNK, 4'd1, O_FACC);
    step("r_decode",    1'b1, RT,   4'd2, O_DEC);
    step("r_exec",      1'b1, JUNK, 4'd7, O_EXEC);
    step("r_aluwb",     1'b1, JUNK, 4'd8, O_AWB);
    // lw with two read stalls
    step("lw_fetch",    1'b1, JUNK, 4'd1, O_FACC);
    step("lw_decode",   1'b1, LW,   4'd2, O_DEC);
    step("lw_memadr",   1'b1, LW,   4'd3, O_MADR);
    step("lw_rd_stl0",  1'b0, JUNK, 4'd4, O_MRD);
    step("lw_rd_stl1",  1'b0, JUNK, 4'd4, O_MRD);
    step("lw_rd_acc",   1'b1, JUNK, 4'd4, O_MRD);
    step("lw_memwb",    1'b1, JUNK, 4'd5, O_MWB);
    // sw with three fetch stalls
    step("sw_f_stl0",   1'b0, JUNK, 4'd1, O_FSTL);
    step("sw_f_stl1",   1'b0, JUNK, 4'd1, O_FSTL);
    step("sw_f_stl2",   1'b0, JUNK, 4'd1, O_FSTL);
    step("sw_f_acc",    1'b1, JUNK, 4'd1, O_FACC);
    step("sw_decode",   1'b1, SW,   4'd2, O_DEC);
    step("sw_memadr",   1'b1, SW,   4'd3, O_MADR);
    step("sw_memwr",    1'b1, JUNK, 4'd6, O_MWR);
    // sw with one write stall: MemWrite must hold
    step("sw2_fetch",   1'b1, JUNK, 4'd1, O_FACC);
    step("sw2_decode",  1'b1, SW,   4'd2, O_DEC);
    step("sw2_memadr",  1'b1, SW,   4'd3, O_MADR);
    step("sw2_wr_stl",  1'b0, JUNK, 4'd6, O_MWR);
    step("sw2_wr_acc",  1'b1, JUNK, 4'd6, O_MWR);
    // beq
    step("beq_fetch",   1'b1, JUNK, 4'd1, O_FACC);
    step("beq_decode",  1'b1, BQ,   4'd2, O_DEC);
    step("beq_branch",  1'b1, JUNK, 4'd9, O_BR);
    // illegal opcode
    step("ill_fetch",   1'b1, JUNK, 4'd1, O_FACC);
    step("ill_decode",  1'b1, BAD,  4'd2, O_DECILL);
    step("ill_refetch", 1'b1, BAD,  4'd1, O_FACC);
    step("ill_after",   1'b1, RT,   4'd2, O_DEC);
    step("r2_exec",     1'b1, JUNK, 4'd7, O_EXEC);

    // asynchronous reset in the middle of an EXEC cycle
    step("r2_aluwb",    1'b1, JUNK, 4'd8, O_AWB);
    step("r3_fetch",    1'b1, JUNK, 4'd1, O_FACC);
    step("r3_decode",   1'b1, RT,   4'd2, O_DEC);
    mem_ready = 1'b1;
    opcode    = JUNK;
    expect_now("r3_exec", 4'd7, O_EXEC);
    @(negedge clk);
    check();
    #2 reset = 1'b1;
    #1;
    expect_now("async_rst", 4'd0, O_IDLE);
    check();
    @(posedge clk);
    #1 reset = 1'b0;
    step("post_idle",   1'b1, JUNK, 4'd0, O_IDLE);
    step("post_fetch",  1'b1, JUNK, 4'd1, O_FACC);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
